// File: rtl/mem_load_reader_if.sv
// Memory read port between the load reader and a word-wide memory.
// Latency: none, plain wires; the reader issues one strobe per load.
// Backpressure: none; the memory answers with mem_rvalid whenever it is ready.
//
// Signals:
//   mem_req    reader -> memory  one-cycle read strobe
//   mem_addr   reader -> memory  word-aligned byte address
//   mem_rvalid memory -> reader  read data valid
//   mem_rdata  memory -> reader  little-endian read word
interface mem_load_reader_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/mem_load_reader.sv
// RV32I load unit: one word read per load, byte/halfword select and sign/zero extension.
// Latency: done 3 cycles after the start cycle with zero memory wait; timeout after TIMEOUT WAIT cycles.
// Backpressure: start is accepted only while idle (busy=0); start while busy is dropped.
//
// Ports: clk, rst (synchronous, active high); start/addr/funct3 load request;
//        rdata/done/busy/err load result and status; mem = memory read port (master side).
// Option: define MEM_LOAD_MISALIGN_CHECK_EN to flag misaligned LH/LHU/LW as errors
//         instead of issuing the read.
module mem_load_reader #(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               addr,
    input  logic [2:0]                funct3,
    output logic [31:0]               rdata,
    output logic                      done,
    output logic                      busy,
    output logic                      err,
    mem_load_reader_if.master         mem
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  addr_lo;
    logic [2:0]  funct3_q;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;
    logic        f3_legal;
    logic        misalign;
    logic        load_ok;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    // Legality of the latched request decides in REQ whether a read is issued at all.
    always_comb begin
        f3_legal = 1'b0;
        case (funct3_q)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
`ifdef MEM_LOAD_MISALIGN_CHECK_EN
        misalign = ((funct3_q[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3_q == 3'b010) && (addr_lo != 2'b00));
`else
        misalign = 1'b0;
`endif
        load_ok = f3_legal && !misalign;
    end

    // The count includes the current WAIT cycle, so the abort happens on the
    // TIMEOUT-th WAIT cycle.
    always_comb begin
        cnt_inc     = cnt + 8'd1;
        timeout_hit = (cnt_inc == TMO);
    end

    // Lane select and extension of the returned word.
    always_comb begin
        sel_byte = mem.mem_rdata[7:0];
        case (addr_lo)
            2'd0:    sel_byte = mem.mem_rdata[7:0];
            2'd1:    sel_byte = mem.mem_rdata[15:8];
            2'd2:    sel_byte = mem.mem_rdata[23:16];
            default: sel_byte = mem.mem_rdata[31:24];
        endcase
        sel_half = addr_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

        ext_data = mem.mem_rdata;
        case (funct3_q)
            3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  ext_data = {24'd0, sel_byte};
            3'b101:  ext_data = {16'd0, sel_half};
            default: ext_data = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem.mem_req = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A rejected request skips the memory entirely.
                mem.mem_req = load_ok;
                state_nxt   = load_ok ? WAIT : DONE;
            end
            WAIT: begin
                // rvalid on the timeout cycle still completes the load normally.
                if (mem.mem_rvalid || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_lo      <= 2'd0;
            funct3_q     <= 3'd0;
            cnt          <= 8'd0;
            err          <= 1'b0;
            rdata        <= 32'd0;
            mem.mem_addr <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_lo      <= addr[1:0];
                        funct3_q     <= funct3;
                        mem.mem_addr <= {addr[31:2], 2'b00};
                        err          <= 1'b0;
                        cnt          <= 8'd0;
                    end
                end
                REQ: begin
                    if (!load_ok) begin
                        err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        rdata <= ext_data;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
